// File: rtl/regfile_bypass_clr_pkg.sv
// Shared definitions for the bypassed register file with sequential clear.
//   clr_state_t : clear engine states (IDLE, CLEAR, DONE)
//   REG_DATA_W  : default register width
//   REG_ADDR_W  : default address width (depth = 2**REG_ADDR_W)
package regfile_bypass_clr_pkg;

  localparam int REG_DATA_W = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_bypass_clr_if.sv
// Bus interface of the register file: read ports, double-width write port,
// clear request/status and the system halt.
//   halt_sys  : freezes writes and the clear engine
//   rd_addr   : NUM_RD packed read addresses, port i in slice i
//   rd_hi_sel : per port, force the read address to the HI register
//   rd_data   : NUM_RD packed read words, port i in slice i
//   we/hi_en/wr_addr/wr_data : write port, wr_data = {high, low}
//   clr_req   : one-cycle request to start a clear sweep
//   clr_busy  : sweep in progress
//   clr_done  : one-cycle completion pulse
// master = issuing pipeline stage, slave = register file.
interface regfile_bypass_clr_if
  import regfile_bypass_clr_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2
);

  logic                     halt_sys;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_hi_sel;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     we;
  logic                     hi_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output halt_sys, rd_addr, rd_hi_sel, we, hi_en, wr_addr, wr_data, clr_req,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
    input  halt_sys, rd_addr, rd_hi_sel, we, hi_en, wr_addr, wr_data, clr_req,
    output rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear engine: walks the register array one entry per non-halted cycle and
// requests a zero write for each entry.
//   clk, rst  : clock, asynchronous active-high reset
//   halt_sys  : holds state and counter, suppresses the clear write
//   clr_req   : start request, honoured only in IDLE
//   clr_busy  : high for the whole sweep (including halted cycles)
//   clr_done  : one-cycle pulse after the last entry is cleared
//   clr_we    : clear-write strobe into the array
//   clr_addr  : entry to clear when clr_we is high
module regfile_clr_fsm
  import regfile_bypass_clr_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // One extra bit keeps the last-entry compare unambiguous for any depth.
  localparam int              CNT_W = ADDR_W + 1;
  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  clr_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req && !halt_sys) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if (!halt_sys) begin
          clr_we  = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/regfile_bypass_clr.sv
// Parametrised register file for the decode/writeback stage.
//   clk, rst : clock, asynchronous active-high reset (clears every register)
//   bus      : regfile_bypass_clr_if slave port
//     - NUM_RD combinational read ports with same-cycle write-through bypass
//     - double-width write: low word to wr_addr, high word to HI_REG if hi_en
//     - clr_req starts a one-entry-per-cycle zeroing sweep (clr_busy/clr_done)
// Writes presented while clr_busy is high are dropped; the issuing stage is
// expected to stall on clr_busy.
module regfile_bypass_clr
  import regfile_bypass_clr_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int HI_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_bypass_clr_if.slave  bus
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_lo;
  logic [DATA_W-1:0] wr_hi;
  logic              wr_eff;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  assign wr_lo  = bus.wr_data[DATA_W-1:0];
  assign wr_hi  = bus.wr_data[2*DATA_W-1:DATA_W];
  assign wr_eff = bus.we && !bus.halt_sys && !bus.clr_busy;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .halt_sys (bus.halt_sys),
    .clr_req  (bus.clr_req),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Clear writes and port writes never coincide: wr_eff is masked by
  // clr_busy and clr_we only fires while busy. The low-word write is issued
  // after the HI write so it wins when wr_addr equals HI_REG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_eff) begin
      if (bus.hi_en) mem[HI_ADDR] <= wr_hi;
      mem[bus.wr_addr] <= wr_lo;
    end
  end

  // Read ports: same priority as the write so bypassed data matches what
  // the array will hold after the edge.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] eff_addr;

    assign eff_addr = bus.rd_hi_sel[i] ? HI_ADDR : bus.rd_addr[i*ADDR_W +: ADDR_W];

    assign bus.rd_data[i*DATA_W +: DATA_W] =
        (wr_eff && (eff_addr == bus.wr_addr))                 ? wr_lo :
        (wr_eff && bus.hi_en && (eff_addr == HI_ADDR))        ? wr_hi :
                                                                mem[eff_addr];
  end

endmodule

// File: tb/tb_regfile_bypass_clr.sv
module tb_regfile_bypass_clr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int HI = 0;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  regfile_bypass_clr_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_bypass_clr #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .HI_REG (HI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain array plus "sweep position / done flag".
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  bit            m_done;
  int            m_idx;
  bit            obs_busy, obs_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
  endtask

  function automatic bit m_weff();
    return bus.we && !bus.halt_sys && !m_busy;
  endfunction

  function automatic logic [DW-1:0] m_read(input int i);
    int a;
    a = bus.rd_hi_sel[i] ? HI : int'(bus.rd_addr[i*AW +: AW]);
    if (m_weff() && a == int'(bus.wr_addr)) return bus.wr_data[DW-1:0];
    if (m_weff() && bus.hi_en && a == HI)   return bus.wr_data[2*DW-1:DW];
    return m_mem[a];
  endfunction

  task automatic m_update();
    bit weff;
    if (rst) begin
      m_reset();
      return;
    end
    weff = m_weff();
    if (m_busy) begin
      if (!bus.halt_sys) begin
        m_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == DEPTH) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.clr_req && !bus.halt_sys) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end
    if (weff) begin
      if (bus.hi_en) m_mem[HI] = bus.wr_data[2*DW-1:DW];
      m_mem[bus.wr_addr] = bus.wr_data[DW-1:0];
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    for (int i = 0; i < NR; i++)
      chk($sformatf("rd%0d", i), 32'(bus.rd_data[i*DW +: DW]), 32'(m_read(i)));
    chk("clr_busy", 32'(bus.clr_busy), 32'(m_busy));
    chk("clr_done", 32'(bus.clr_done), 32'(m_done));
    obs_busy = bus.clr_busy;
    obs_done = bus.clr_done;
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.halt_sys  = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_hi_sel = '0;
    bus.we        = 1'b0;
    bus.hi_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input logic [1:0] hs);
    bus.rd_addr   = {AW'(a1), AW'(a0)};
    bus.rd_hi_sel = hs;
  endtask

  initial begin
    int busy_cnt, done_cnt;

    rst = 1'b1;
    idle_inputs();
    m_reset();
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;

    // Reset state: every address reads zero on both ports.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a, 2'b00);
      step();
    end

    // Double-width write with same-cycle bypass on both ports.
    bus.we = 1'b1; bus.hi_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h1234_ABCD;
    set_rd(5, 9, 2'b10);
    #1;
    chk("byp_lo", 32'(bus.rd_data[DW-1:0]), 32'h0000_ABCD);
    chk("byp_hi", 32'(bus.rd_data[2*DW-1:DW]), 32'h0000_1234);
    #1;
    step();
    idle_inputs();
    set_rd(5, 0, 2'b00);
    #1;
    chk("reg5", 32'(bus.rd_data[DW-1:0]), 32'h0000_ABCD);
    chk("reg0", 32'(bus.rd_data[2*DW-1:DW]), 32'h0000_1234);
    step();

    // Low word wins when the write address is the HI register.
    bus.we = 1'b1; bus.hi_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 32'hFFFF_0001;
    set_rd(0, 0, 2'b10);
    step();
    idle_inputs();
    set_rd(0, 5, 2'b00);
    #1;
    chk("lo_wins", 32'(bus.rd_data[DW-1:0]), 32'h0000_0001);
    step();

    // Fill with 0x00AA, then sweep with halt on sweep cycles 3 and 4.
    for (int a = 0; a < DEPTH; a++) begin
      bus.we = 1'b1; bus.hi_en = 1'b0; bus.wr_addr = AW'(a); bus.wr_data = 32'h0000_00AA;
      set_rd(a, (a + 1) % DEPTH, 2'b00);
      step();
    end
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      idle_inputs();
      bus.halt_sys = (k == 3 || k == 4);
      set_rd(15, 3, 2'b00);
      if (k == 6) begin
        bus.we = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h0000_5555;
      end
      if (k == 8) bus.clr_req = 1'b1;
      if (k == 5) begin
        #1;
        chk("mid_reg15", 32'(bus.rd_data[DW-1:0]), 32'h0000_00AA);
        #1;
      end
      step();
      if (obs_busy) busy_cnt++;
      if (obs_done) done_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd18);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, a, 2'b00);
      #1;
      chk($sformatf("swept%0d", a), 32'(bus.rd_data[DW-1:0]), 32'h0);
      #1;
      step();
    end

    // Reset in the middle of a sweep.
    for (int a = 0; a < DEPTH; a++) begin
      bus.we = 1'b1; bus.hi_en = 1'($urandom_range(0, 1));
      bus.wr_addr = AW'(a); bus.wr_data = $urandom;
      step();
    end
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_rd(15, k, 2'b00);
      step();
    end
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_busy", 32'(bus.clr_busy), 32'd0);
    chk("rst_done", 32'(bus.clr_done), 32'd0);
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, 15 - a, 2'b00);
      step();
      if (obs_done) done_cnt++;
    end
    chk("rst_no_done", 32'(done_cnt), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bus.halt_sys  = ($urandom_range(0, 7) == 0);
      bus.clr_req   = ($urandom_range(0, 59) == 0);
      bus.we        = 1'($urandom_range(0, 1));
      bus.hi_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = $urandom;
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
